// File: rtl/data_mem_pkg.sv
// Shared defaults and encodings for the block-organised data memory.
package data_mem_pkg;

    localparam int unsigned DEF_BLOCK_BITS = 256;
    localparam int unsigned DEF_ADDR_BITS  = 5;
    localparam int unsigned DEF_LATENCY    = 10;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef enum logic {
        READ,
        WRITE
    } op_t;

endpackage

// File: rtl/data_mem_array.sv
// Block storage: one synchronous write port, one combinational read port.
// DATA_MEM_PRELOAD_EN seeds every block with its own index at simulation start.
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int unsigned BLOCK_BITS = DEF_BLOCK_BITS,
    parameter int unsigned ADDR_BITS  = DEF_ADDR_BITS
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  waddr,
    input  logic [BLOCK_BITS-1:0] wdata,
    input  logic [ADDR_BITS-1:0]  raddr,
    output logic [BLOCK_BITS-1:0] rdata
);

    logic [BLOCK_BITS-1:0] mem [0:(2**ADDR_BITS)-1];

`ifdef DATA_MEM_PRELOAD_EN
    initial begin
        for (int unsigned k = 0; k < 2**ADDR_BITS; k++) begin
            mem[k] = {(BLOCK_BITS/32){32'(k)}};
        end
    end
`else
`endif

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem.sv
// data_mem: main-memory model serving one whole-block read or write per request
// with fixed latency. DATA_MEM_PRELOAD_EN (in data_mem_array) preloads contents.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int unsigned BLOCK_BITS = DEF_BLOCK_BITS,
    parameter int unsigned ADDR_BITS  = DEF_ADDR_BITS,
    parameter int unsigned LATENCY    = DEF_LATENCY
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ren,
    input  logic                  wen,
    input  logic [ADDR_BITS-1:0]  block_address,
    input  logic [BLOCK_BITS-1:0] din,
    output logic                  ready,
    output logic                  done,
    output logic [BLOCK_BITS-1:0] dout
);

    localparam int unsigned CNT_BITS = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(LATENCY - 1);

    state_t                state_q, state_d;
    op_t                   op_q, op_c;
    logic [CNT_BITS-1:0]   count_q, count_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_c;
    logic [BLOCK_BITS-1:0] din_q, din_c, rdata, dout_q;
    logic                  ready_q, accept, finish, mem_we;

    // Live inputs feed the commit only when LATENCY==1 (accept and finish on one edge).
    assign accept = ready_q && (ren || wen);
    assign op_c   = accept ? (wen ? WRITE : READ) : op_q;
    assign addr_c = accept ? block_address : addr_q;
    assign din_c  = accept ? din : din_q;
    assign mem_we = reset && finish && (op_c == WRITE);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        finish  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    count_d = CNT_LOAD;
                    if (LATENCY == 1) begin
                        finish  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (count_q == CNT_BITS'(1)) begin
                    finish  = 1'b1;
                    count_d = '0;
                    state_d = DONE;
                end else begin
                    count_d = count_q - CNT_BITS'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            ready_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ready_q <= (state_d == IDLE);
            if (finish && (op_c == READ)) begin
                dout_q <= rdata;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            addr_q <= block_address;
            din_q  <= din;
            op_q   <= op_c;
        end
    end

    data_mem_array #(
        .BLOCK_BITS (BLOCK_BITS),
        .ADDR_BITS  (ADDR_BITS)
    ) u_array (
        .clock (clock),
        .we    (mem_we),
        .waddr (addr_c),
        .wdata (din_c),
        .raddr (addr_c),
        .rdata (rdata)
    );

    assign ready = ready_q;
    assign done  = (state_q == DONE);
    assign dout  = dout_q;

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: driver queues expected completions, monitor checks on done.
module tb_data_mem;

    localparam int LAT = 10;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         ren = 1'b0;
    logic         wen = 1'b0;
    logic [4:0]   block_address = '0;
    logic [255:0] din = '0;
    logic         ready, done;
    logic [255:0] dout;

    data_mem #(
        .BLOCK_BITS (256),
        .ADDR_BITS  (5),
        .LATENCY    (LAT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ren           (ren),
        .wen           (wen),
        .block_address (block_address),
        .din           (din),
        .ready         (ready),
        .done          (done),
        .dout          (dout)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit           is_read;
        logic [255:0] data;
        int           exp_cyc;
    } exp_t;

    exp_t         sb[$];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    logic [255:0] last_rd = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, want);
        end
    endtask

    // Monitor: pops one expectation per done pulse; otherwise dout must hold the last read.
    always @(negedge clock) begin
        if (!reset) begin
            last_rd = '0;
        end else if (done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pending request", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_latency", 256'(cyc), 256'(e.exp_cyc));
                if (e.is_read) begin
                    check("read_data", dout, e.data);
                    last_rd = e.data;
                end else begin
                    check("write_keeps_dout", dout, last_rd);
                end
            end
        end else begin
            check("dout_hold", dout, last_rd);
        end
    end

    task automatic do_op(input bit r, input bit w, input logic [4:0] a, input logic [255:0] d,
                         input bit push, input logic [255:0] expd);
        int t = 0;
        @(posedge clock); #1;
        while (!ready && t < 100) begin
            @(posedge clock); #1;
            t++;
        end
        if (!ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got ready=0 after %0d cycles, required 1", t);
        end else begin
            ren = r;
            wen = w;
            block_address = a;
            din = d;
            if (push) sb.push_back('{is_read: (r && !w), data: expd, exp_cyc: cyc + LAT});
            @(posedge clock); #1;
            ren = 1'b0;
            wen = 1'b0;
            block_address = ~a;
            din = ~d;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clock); #1;
            t++;
        end
        check("queue_drained", 256'(sb.size()), 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        bit done_seen;

        // Reset held for two edges
        reset = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("reset_ready", ready, 0);
        check("reset_done", done, 0);
        check("reset_dout", dout, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        check("ready_after_release", ready, 1);
        check("done_after_release", done, 0);

        // Fill every block with addr+1
        for (int a = 0; a < 32; a++) do_op(1'b0, 1'b1, 5'(a), 256'(a + 1), 1'b1, '0);
        drain();

        // Read them all back
        for (int a = 0; a < 32; a++) do_op(1'b1, 1'b0, 5'(a), '0, 1'b1, 256'(a + 1));
        drain();

        // ren held; address churns every half cycle during BUSY
        do_op(1'b0, 1'b0, 5'd0, '0, 1'b0, '0);
        ren = 1'b1;
        block_address = 5'd10;
        sb.push_back('{is_read: 1'b1, data: 256'd11, exp_cyc: cyc + LAT});
        @(posedge clock); #1;
        done_seen = 1'b0;
        for (int i = 0; i < 2 * LAT; i++) begin
            block_address = 5'($urandom_range(11, 31));
            @(negedge clock); #1;
            if (done) begin
                done_seen = 1'b1;
                break;
            end
            block_address = 5'($urandom_range(11, 31));
            @(posedge clock); #1;
        end
        check("held_ren_done_seen", done_seen, 1);
        block_address = 5'd12;
        sb.push_back('{is_read: 1'b1, data: 256'd13, exp_cyc: cyc + 1 + LAT});
        @(posedge clock); #1;
        check("ready_after_done", ready, 1);
        @(posedge clock); #1;
        ren = 1'b0;
        check("ready_after_reaccept", ready, 0);
        drain();

        // Write aborted by reset mid-BUSY must not land
        do_op(1'b0, 1'b1, 5'd4, 256'hDEAD, 1'b0, '0);
        repeat (3) begin
            @(posedge clock); #1;
        end
        reset = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("midop_reset_ready", ready, 0);
        check("midop_reset_done", done, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        check("midop_release_ready", ready, 1);
        repeat (LAT + 2) begin
            @(posedge clock); #1;
        end
        do_op(1'b1, 1'b0, 5'd4, '0, 1'b1, 256'd5);
        drain();

        // Simultaneous ren/wen: write wins
        do_op(1'b1, 1'b1, 5'd7, 256'hA5, 1'b1, '0);
        do_op(1'b1, 1'b0, 5'd7, '0, 1'b1, 256'hA5);
        drain();

        repeat (3) begin
            @(posedge clock); #1;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
